fork_join_sched: RTL and testbench

- Synthesizable multi-thread launcher: one fork request starts up to N_THREADS concurrent countdown "threads", each with its own cycle duration.
- Supports fork/join semantics: JOIN_ALL, JOIN_ANY and JOIN_NONE.
- Signals a per-thread completion pulse and a join pulse that triggers the continuation logic downstream.
- Used as a sequencing primitive in control paths and as a cycle-accurate model of fork/join timing in benches.

---
 rtl/fork_join_sched_if.sv | 25 ++
 rtl/fork_join_sched.sv | 106 ++++++++++
 tb/tb_fork_join_sched.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fork_join_sched_if.sv
// rtl/fork_join_sched_if.sv - fork request, join status and per-thread status bundle
interface fork_join_sched_if #(
   parameter int N_THREADS = 4,
   parameter int CNT_W     = 8
);
   logic                         fork_valid;
   logic                         fork_ready;
   logic [N_THREADS-1:0]         fork_mask;
   logic [N_THREADS*CNT_W-1:0]   fork_dur;
   logic [1:0]                   join_mode;
   logic [N_THREADS-1:0]         busy;
   logic [N_THREADS-1:0]         done_pulse;
   logic                         join_done;
   logic [CNT_W:0]               join_latency;

   modport master (
      output fork_valid, fork_mask, fork_dur, join_mode,
      input  fork_ready, busy, done_pulse, join_done, join_latency
   );

   modport slave (
      input  fork_valid, fork_mask, fork_dur, join_mode,
      output fork_ready, busy, done_pulse, join_done, join_latency
   );
endinterface

// File: rtl/fork_join_sched.sv
// rtl/fork_join_sched.sv - fork/join launcher of countdown threads with JOIN_ALL/ANY/NONE
// Each slot counts its duration down; the join pulse fires per the latched join mode.
module fork_join_sched #(
   parameter int N_THREADS = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   fork_join_sched_if.slave bus
);
   typedef enum logic {IDLE, WAIT} state_e;

   state_e               state_q;
   logic [N_THREADS-1:0] busy_q;
   logic [N_THREADS-1:0] done_q;
   logic [N_THREADS-1:0] pending_q;
   logic [N_THREADS-1:0] pending_d;
   logic [N_THREADS-1:0] finish;
   logic [CNT_W-1:0]     cnt_q [N_THREADS];
   logic [1:0]           mode_q;
   logic [CNT_W:0]       lat_q;
   logic [CNT_W:0]       join_lat_q;
   logic                 join_q;
   logic                 accept;
   logic                 join_hit;

   always_comb begin
      finish = '0;
      for (int i = 0; i < N_THREADS; i++) begin
         finish[i] = busy_q[i] && (cnt_q[i] == '0);
      end
   end

   assign pending_d      = pending_q & ~finish;
   assign bus.fork_ready = (state_q == IDLE) && ((bus.fork_mask & busy_q) == '0);
   assign accept         = bus.fork_valid && bus.fork_ready;

   // An empty fork has nothing to wait for, so every mode joins on the first edge.
   always_comb begin
      join_hit = 1'b0;
      case (mode_q)
         2'd1:    join_hit = (pending_q == '0) || ((pending_q & finish) != '0);
         2'd2:    join_hit = 1'b1;
         default: join_hit = (pending_d == '0);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= '0;
         done_q     <= '0;
         pending_q  <= '0;
         mode_q     <= 2'd0;
         lat_q      <= '0;
         join_lat_q <= '0;
         join_q     <= 1'b0;
         for (int i = 0; i < N_THREADS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         done_q     <= finish;
         join_q     <= 1'b0;
         join_lat_q <= '0;
         for (int i = 0; i < N_THREADS; i++) begin
            if (accept && bus.fork_mask[i]) begin
               busy_q[i] <= 1'b1;
               cnt_q[i]  <= bus.fork_dur[i*CNT_W +: CNT_W];
            end else if (busy_q[i]) begin
               if (cnt_q[i] != '0) begin
                  cnt_q[i] <= cnt_q[i] - 1'b1;
               end else begin
                  busy_q[i] <= 1'b0;
               end
            end
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  pending_q <= bus.fork_mask;
                  mode_q    <= bus.join_mode;
                  lat_q     <= {{CNT_W{1'b0}}, 1'b1};
                  state_q   <= WAIT;
               end
            end
            WAIT: begin
               pending_q <= pending_d;
               if (lat_q != '1) begin
                  lat_q <= lat_q + 1'b1;
               end
               if (join_hit) begin
                  join_q     <= 1'b1;
                  join_lat_q <= lat_q;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done_pulse   = done_q;
   assign bus.join_done    = join_q;
   assign bus.join_latency = join_lat_q;
endmodule

// File: tb/tb_fork_join_sched.sv
// tb/tb_fork_join_sched.sv - scoreboard bench for fork_join_sched with directed and random forks
module tb_fork_join_sched;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fork_join_sched_if #(.N_THREADS(N), .CNT_W(W)) bus();
   fork_join_sched #(.N_THREADS(N), .CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int ecnt  = 0;
   int tests = 0;
   int fails = 0;

   // Reference model: edge numbers at which things happen, derived from the fork rules.
   int busy_end [N];
   int join_at = 0;
   int dq [N][$];
   int jq_edge [$];
   int jq_lat [$];

   always @(posedge clk) ecnt = ecnt + 1;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic model_ready(input logic [N-1:0] m);
      logic r;
      r = (join_at <= ecnt);
      for (int i = 0; i < N; i++) begin
         if (m[i] && busy_end[i] > ecnt) r = 1'b0;
      end
      return r;
   endfunction

   task automatic model_accept(input int e, input logic [N-1:0] m, input int d [N], input logic [1:0] jm);
      int mx, mn, lat;
      mx = -1;
      mn = 1 << 30;
      for (int i = 0; i < N; i++) begin
         if (m[i]) begin
            busy_end[i] = e + d[i] + 1;
            dq[i].push_back(e + d[i] + 1);
            if (d[i] > mx) mx = d[i];
            if (d[i] < mn) mn = d[i];
         end
      end
      if (m == '0 || jm == 2'd2) lat = 1;
      else if (jm == 2'd1)       lat = mn + 1;
      else                       lat = mx + 1;
      join_at = e + lat;
      jq_edge.push_back(e + lat);
      jq_lat.push_back(lat);
   endtask

   task automatic do_fork(input logic [N-1:0] m, input int d [N], input logic [1:0] jm);
      logic mr;
      int waited;
      waited = 0;
      bus.fork_valid = 1'b1;
      bus.fork_mask  = m;
      bus.join_mode  = jm;
      for (int i = 0; i < N; i++) bus.fork_dur[i*W +: W] = d[i][W-1:0];
      forever begin
         #1;
         mr = model_ready(m);
         tests++;
         if (bus.fork_ready !== mr) begin
            fails++;
            $display("FAIL fork_ready edge %0d mask %b: got %b want %b", ecnt, m, bus.fork_ready, mr);
         end
         if (mr) begin
            model_accept(ecnt + 1, m, d, jm);
            step();
            break;
         end
         if (waited > 400) begin
            fails++;
            $display("FAIL fork_accept_timeout mask %b: got no accept want accept", m);
            step();
            break;
         end
         waited++;
         step();
      end
      bus.fork_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      logic idle;
      n = 0;
      forever begin
         idle = (join_at <= ecnt);
         for (int i = 0; i < N; i++) if (busy_end[i] > ecnt) idle = 1'b0;
         if (idle) break;
         if (n > 600) begin
            fails++;
            $display("FAIL idle_timeout edge %0d: got busy want idle", ecnt);
            break;
         end
         n++;
         step();
      end
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         busy_end[i] = 0;
         dq[i].delete();
      end
      join_at = 0;
      jq_edge.delete();
      jq_lat.delete();
      #2;
      rst = 1'b0;
   endtask

   // Monitor: compares every cycle against the expectation queues.
   initial begin
      logic eb, ep, ej;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            eb = busy_end[i] > ecnt;
            tests++;
            if (bus.busy[i] !== eb) begin
               fails++;
               $display("FAIL busy[%0d] edge %0d: got %b want %b", i, ecnt, bus.busy[i], eb);
            end
            ep = (dq[i].size() > 0) && (dq[i][0] == ecnt);
            tests++;
            if (bus.done_pulse[i] !== ep) begin
               fails++;
               $display("FAIL done_pulse[%0d] edge %0d: got %b want %b", i, ecnt, bus.done_pulse[i], ep);
            end
            if (ep) void'(dq[i].pop_front());
         end
         ej = (jq_edge.size() > 0) && (jq_edge[0] == ecnt);
         tests++;
         if (bus.join_done !== ej) begin
            fails++;
            $display("FAIL join_done edge %0d: got %b want %b", ecnt, bus.join_done, ej);
         end
         tests++;
         if (ej) begin
            if (bus.join_latency !== jq_lat[0][W:0]) begin
               fails++;
               $display("FAIL join_latency edge %0d: got %0d want %0d", ecnt, bus.join_latency, jq_lat[0]);
            end
            void'(jq_edge.pop_front());
            void'(jq_lat.pop_front());
         end else if (bus.join_latency !== '0) begin
            fails++;
            $display("FAIL join_latency_idle edge %0d: got %0d want 0", ecnt, bus.join_latency);
         end
      end
   end

   initial begin
      int d [N];
      logic mr;
      int left;
      bus.fork_valid = 1'b0;
      bus.fork_mask  = '0;
      bus.fork_dur   = '0;
      bus.join_mode  = 2'd0;
      repeat (3) step();
      rst = 1'b0;
      step();

      d = '{20, 30, 0, 0};
      do_fork(4'b0011, d, 2'd2);
      wait_idle();
      do_fork(4'b0011, d, 2'd0);
      wait_idle();
      do_fork(4'b0011, d, 2'd1);
      d = '{5, 0, 0, 0};
      do_fork(4'b0001, d, 2'd1);
      wait_idle();

      d = '{0, 5, 40, 0};
      do_fork(4'b0110, d, 2'd1);
      d = '{0, 0, 3, 0};
      do_fork(4'b0100, d, 2'd1);
      wait_idle();

      d = '{0, 0, 0, 0};
      do_fork(4'b1111, d, 2'd0);
      do_fork(4'b0000, d, 2'd0);
      do_fork(4'b0000, d, 2'd1);
      do_fork(4'b0000, d, 2'd3);
      wait_idle();

      d = '{20, 0, 0, 0};
      do_fork(4'b0001, d, 2'd0);
      repeat (9) step();
      do_reset();
      bus.fork_mask = 4'b1111;
      #1;
      mr = model_ready(4'b1111);
      tests++;
      if (bus.fork_ready !== mr) begin
         fails++;
         $display("FAIL ready_after_reset: got %b want %b", bus.fork_ready, mr);
      end
      repeat (30) step();

      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < N; i++) d[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 40));
         do_fork(4'($urandom_range(0, 15)), d, 2'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 3)) step();
      end
      wait_idle();
      repeat (2) step();

      left = jq_edge.size();
      for (int i = 0; i < N; i++) left += dq[i].size();
      tests++;
      if (left != 0) begin
         fails++;
         $display("FAIL leftover_expectations: got %0d outstanding want 0", left);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
